// File: rtl/hyperbus_wb.sv
// hyperbus_wb: Wishbone slave bridging 32-bit accesses onto a 16-bit
// HyperBus controller request interface.
//
// Each Wishbone access is latched in IDLE and split into two 16-bit words,
// low half first.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   wb_*_i / wb_*_o     Wishbone slave: adr, dat, sel, we, cyc, stb, ack, err
//   hb_adr_o            16-bit word address, held from latch until IDLE
//   hb_reg_space_o      latched wb_adr_i[31]
//   hb_wrq_o, hb_rrq_o  write / read request, high only while words are due
//   hb_dat_o, hb_mask_o write word and RWDS byte mask (1 = byte masked)
//   hb_dat_i, hb_valid_i read word, qualified by hb_valid_i
//   hb_ready_i          write word consumed
//   dbg_state_o         current FSM state encoding
//
// Handshake: a write word is transferred on every rising edge where
// hb_wrq_o and hb_ready_i are both 1. A read word is transferred on every
// rising edge where hb_rrq_o and hb_valid_i are both 1. Neither side may
// retract a word once offered, and strobes outside those states are ignored.
module hyperbus_wb #(
  parameter int ADDR_LENGTH   = 32,
  parameter int TIMEOUT_COUNT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [ADDR_LENGTH-1:0] hb_adr_o,
  output logic [15:0]            hb_dat_o,
  output logic [1:0]             hb_mask_o,
  input  logic [15:0]            hb_dat_i,
  input  logic                   hb_valid_i,
  input  logic                   hb_ready_i,
  output logic                   hb_reg_space_o,
  output logic                   hb_wrq_o,
  output logic                   hb_rrq_o,
  output logic [2:0]             dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    RD0  = 3'd3,
    RD1  = 3'd4,
    ACK  = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] hadr_q, hadr_d;
  logic                   reg_q, reg_d;
  logic [31:0]            dat_q, dat_d;
  logic [3:0]             sel_q, sel_d;
  logic [31:0]            rdat_q, rdat_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic                   busy;
  logic                   expired;

  // Byte address bit 0 has no meaning for a 16-bit word address.
  logic unused_adr0;
  assign unused_adr0 = wb_adr_i[0];

  assign busy = (state_q == WR0) || (state_q == WR1) ||
                (state_q == RD0) || (state_q == RD1);
  // The counter saturates at TIMEOUT_COUNT, so ">=" still catches expiry
  // when a handshake won the race on the expiring cycle.
  assign expired = (cnt_q >= CW'(TIMEOUT_COUNT - 1));

  always_comb begin
    state_d  = state_q;
    hadr_d   = hadr_q;
    reg_d    = reg_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    rdat_d   = rdat_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    hb_wrq_o  = 1'b0;
    hb_rrq_o  = 1'b0;
    hb_dat_o  = 16'h0000;
    hb_mask_o = 2'b11;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;

    if (busy) begin
      cnt_d = (cnt_q == CW'(TIMEOUT_COUNT)) ? cnt_q : cnt_q + CW'(1);
      // A master that walked away still lets the burst finish, but must
      // not see a stray ack/err belonging to the abandoned cycle.
      if (!wb_cyc_i) abort_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          hadr_d  = ADDR_LENGTH'({1'b0, wb_adr_i[30:1]});
          reg_d   = wb_adr_i[31];
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = wb_we_i ? WR0 : RD0;
        end
      end
      WR0: begin
        hb_wrq_o  = 1'b1;
        hb_dat_o  = dat_q[15:0];
        hb_mask_o = ~sel_q[1:0];
        if (hb_ready_i)   state_d = WR1;
        else if (expired) state_d = ERR;
      end
      WR1: begin
        hb_wrq_o  = 1'b1;
        hb_dat_o  = dat_q[31:16];
        hb_mask_o = ~sel_q[3:2];
        if (hb_ready_i)   state_d = ACK;
        else if (expired) state_d = ERR;
      end
      RD0: begin
        hb_rrq_o = 1'b1;
        if (hb_valid_i) begin
          rdat_d[15:0] = hb_dat_i;
          state_d      = RD1;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      RD1: begin
        hb_rrq_o = 1'b1;
        if (hb_valid_i) begin
          rdat_d[31:16] = hb_dat_i;
          state_d       = ACK;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      ACK: begin
        wb_ack_o = !abort_q;
        state_d  = IDLE;
      end
      ERR: begin
        wb_err_o = !abort_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hadr_q  <= '0;
      reg_q   <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hadr_q  <= hadr_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign wb_dat_o       = rdat_q;
  assign hb_adr_o       = hadr_q;
  assign hb_reg_space_o = reg_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_hyperbus_wb.sv
// Self-checking bench for hyperbus_wb (TIMEOUT_COUNT = 16).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_hyperbus_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  logic [31:0] hb_adr_o;
  logic [15:0] hb_dat_o, hb_dat_i;
  logic [1:0]  hb_mask_o;
  logic        hb_valid_i, hb_ready_i, hb_reg_space_o, hb_wrq_o, hb_rrq_o;
  logic [2:0]  dbg_state_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  hyperbus_wb #(.ADDR_LENGTH(32), .TIMEOUT_COUNT(16)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .hb_adr_o(hb_adr_o), .hb_dat_o(hb_dat_o), .hb_mask_o(hb_mask_o),
    .hb_dat_i(hb_dat_i), .hb_valid_i(hb_valid_i), .hb_ready_i(hb_ready_i),
    .hb_reg_space_o(hb_reg_space_o), .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  task automatic drop_req();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    hb_dat_i = '0; hb_valid_i = 1'b0; hb_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_ack_o, wb_err_o, hb_wrq_o, hb_rrq_o, hb_mask_o, hb_reg_space_o} !== 7'b0000110) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b exp %b",
               {wb_ack_o, wb_err_o, hb_wrq_o, hb_rrq_o, hb_mask_o, hb_reg_space_o}, 7'b0000110);
    end
    n_vec++;
    if ({wb_dat_o, hb_dat_o, hb_adr_o} !== 80'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h/%h/%h exp 0", wb_dat_o, hb_dat_o, hb_adr_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write(input string name, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    int hs = 0;
    int hs2_c = -10;
    int acks = 0;
    int errs = 0;
    int gap = $urandom_range(0, 3);
    logic [31:0] exp;
    exp_q.push_back({14'b0, ~sel[1:0], dat[15:0]});
    exp_q.push_back({14'b0, ~sel[3:2], dat[31:16]});
    start_req(adr, dat, sel, 1'b1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      hb_ready_i = 1'b0;
      if (acks > 0 && !wb_ack_o) break;
      if (wb_err_o) errs++;
      if (wb_ack_o) begin
        acks++;
        drop_req();
        n_vec++;
        if (c != hs2_c + 1) begin
          n_bad++;
          $display("FAIL %s_ack_latency got cycle %0d exp %0d", name, c, hs2_c + 1);
        end
        // Controller takes an extra word after the request dropped.
        hb_ready_i = 1'b1;
        n_vec++;
        if ({hb_wrq_o, hb_mask_o} !== 3'b011) begin
          n_bad++;
          $display("FAIL %s_post_mask got %b exp 011", name, {hb_wrq_o, hb_mask_o});
        end
      end
      if (hb_wrq_o) begin
        if (c == 0) begin
          n_vec++;
          if ({hb_reg_space_o, hb_adr_o} !== {adr[31], 2'b00, adr[30:1]}) begin
            n_bad++;
            $display("FAIL %s_adr got %b/%h exp %b/%h", name, hb_reg_space_o, hb_adr_o,
                     adr[31], {2'b00, adr[30:1]});
          end
        end
        if (gap == 0) begin
          hb_ready_i = 1'b1;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_word got %h exp none", name, hb_dat_o);
          end else begin
            exp = exp_q.pop_front();
            if ({14'b0, hb_mask_o, hb_dat_o} !== exp) begin
              n_bad++;
              $display("FAIL %s_word%0d got %h exp %h", name, hs,
                       {14'b0, hb_mask_o, hb_dat_o}, exp);
            end
          end
          hs++;
          if (hs == 2) hs2_c = c;
          gap = $urandom_range(0, 3);
        end else begin
          gap--;
        end
      end
    end
    hb_ready_i = 1'b0;
    drop_req();
    n_vec++;
    if (acks != 1 || errs != 0 || hs != 2) begin
      n_bad++;
      $display("FAIL %s_pulses got ack=%0d err=%0d words=%0d exp 1/0/2", name, acks, errs, hs);
    end
  endtask

  task automatic test_read(input string name, input logic [31:0] adr,
                           input logic [15:0] lo, input logic [15:0] hi);
    int hs = 0;
    int hs2_c = -10;
    int acks = 0;
    int errs = 0;
    int gap = $urandom_range(0, 3);
    logic [31:0] exp;
    exp_q.push_back({hi, lo});
    start_req(adr, 32'h0, 4'hF, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      hb_valid_i = 1'b0;
      hb_dat_i   = 16'hFFFF;
      if (acks > 0 && !wb_ack_o) break;
      if (wb_err_o) errs++;
      if (wb_ack_o) begin
        acks++;
        drop_req();
        n_vec++;
        if (c != hs2_c + 1) begin
          n_bad++;
          $display("FAIL %s_ack_latency got cycle %0d exp %0d", name, c, hs2_c + 1);
        end
        n_vec++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        if (wb_dat_o !== exp) begin
          n_bad++;
          $display("FAIL %s_data got %h exp %h", name, wb_dat_o, exp);
        end
      end
      if (hb_rrq_o) begin
        if (c == 0) begin
          n_vec++;
          if ({hb_reg_space_o, hb_adr_o} !== {adr[31], 2'b00, adr[30:1]}) begin
            n_bad++;
            $display("FAIL %s_adr got %b/%h exp %b/%h", name, hb_reg_space_o, hb_adr_o,
                     adr[31], {2'b00, adr[30:1]});
          end
        end
        if (gap == 0) begin
          hb_valid_i = 1'b1;
          hb_dat_i   = (hs == 0) ? lo : hi;
          hs++;
          if (hs == 2) hs2_c = c;
          gap = $urandom_range(0, 3);
        end else begin
          gap--;
        end
      end
    end
    hb_valid_i = 1'b0;
    drop_req();
    n_vec++;
    if (acks != 1 || errs != 0) begin
      n_bad++;
      $display("FAIL %s_pulses got ack=%0d err=%0d exp 1/0", name, acks, errs);
    end
  endtask

  task automatic test_timeout();
    int rrq_n = 0;
    int errs = 0;
    int acks = 0;
    int err_c = -1;
    start_req(32'h0000_0040, 32'h0, 4'hF, 1'b0);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (hb_rrq_o) rrq_n++;
      if (wb_ack_o) acks++;
      if (wb_err_o) begin
        errs++;
        err_c = c;
        drop_req();
      end
    end
    drop_req();
    n_vec++;
    if (rrq_n != 16) begin
      n_bad++;
      $display("FAIL timeout_rrq_cycles got %0d exp 16", rrq_n);
    end
    n_vec++;
    if (errs != 1 || acks != 0 || err_c != 16) begin
      n_bad++;
      $display("FAIL timeout_err got err=%0d ack=%0d at %0d exp 1/0 at 16", errs, acks, err_c);
    end
  endtask

  // Ready arrives on the very cycle the counter expires: the word must go.
  task automatic test_handshake_wins();
    logic [31:0] exp;
    int errs = 0;
    int acks = 0;
    exp_q.push_back({14'b0, 2'b00, 16'h3C3C});
    start_req(32'h0000_0200, 32'h7777_3C3C, 4'hF, 1'b1);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      hb_ready_i = 1'b0;
      if (wb_ack_o) acks++;
      if (wb_err_o) begin
        errs++;
        drop_req();
        n_vec++;
        if (c != 17) begin
          n_bad++;
          $display("FAIL race_err_cycle got %0d exp 17", c);
        end
      end
      if (c == 15) begin
        hb_ready_i = 1'b1;
        exp = exp_q.pop_front();
        n_vec++;
        if ({hb_wrq_o, 13'b0, hb_mask_o, hb_dat_o} !== {1'b1, exp[30:0]}) begin
          n_bad++;
          $display("FAIL race_word0 got %b/%h exp 1/%h", hb_wrq_o, {hb_mask_o, hb_dat_o}, exp);
        end
      end
      if (c == 16) begin
        n_vec++;
        if ({hb_wrq_o, hb_dat_o} !== {1'b1, 16'h7777}) begin
          n_bad++;
          $display("FAIL race_wr1 got %b/%h exp 1/7777", hb_wrq_o, hb_dat_o);
        end
      end
    end
    drop_req();
    n_vec++;
    if (errs != 1 || acks != 0) begin
      n_bad++;
      $display("FAIL race_pulses got err=%0d ack=%0d exp 1/0", errs, acks);
    end
  endtask

  task automatic test_reset_in_wr1();
    int pulses = 0;
    start_req(32'h0000_0020, 32'hCAFE_BEEF, 4'hF, 1'b1);
    @(negedge clk);
    hb_ready_i = 1'b1;                       // WR0 word accepted
    @(negedge clk);
    hb_ready_i = 1'b0;
    n_vec++;
    if (hb_wrq_o !== 1'b1 || hb_dat_o !== 16'hCAFE) begin
      n_bad++;
      $display("FAIL rst_wr1_setup got %b/%h exp 1/cafe", hb_wrq_o, hb_dat_o);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({wb_ack_o, wb_err_o, hb_wrq_o, hb_rrq_o, hb_mask_o, hb_reg_space_o} !== 7'b0000110 ||
        {wb_dat_o, hb_dat_o, hb_adr_o} !== 80'h0) begin
      n_bad++;
      $display("FAIL rst_wr1_outputs got %b %h/%h/%h exp 0000110 0",
               {wb_ack_o, wb_err_o, hb_wrq_o, hb_rrq_o, hb_mask_o, hb_reg_space_o},
               wb_dat_o, hb_dat_o, hb_adr_o);
    end
    drop_req();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL rst_wr1_pulse got %0d exp 0", pulses);
    end
    test_write("after_rst", 32'h0000_0044, 32'h0102_0304, 4'hF);
  endtask

  task automatic test_cyc_drop();
    int pulses = 0;
    exp_q.push_back(32'h2222_1111);
    start_req(32'h0000_0100, 32'h0, 4'hF, 1'b0);
    @(negedge clk);                          // RD0
    drop_req();
    hb_valid_i = 1'b1; hb_dat_i = 16'h1111;
    @(negedge clk);                          // RD1
    hb_valid_i = 1'b1; hb_dat_i = 16'h2222;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      hb_valid_i = 1'b0;
      if (wb_ack_o || wb_err_o) pulses++;
    end
    n_vec++;
    if (pulses != 0 || hb_rrq_o !== 1'b0 || dbg_state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL cyc_drop_end got pulses=%0d rrq=%b state=%0d exp 0/0/0",
               pulses, hb_rrq_o, dbg_state_o);
    end
    n_vec++;
    if (wb_dat_o !== exp_q[0]) begin
      n_bad++;
      $display("FAIL cyc_drop_data got %h exp %h", wb_dat_o, exp_q[0]);
    end
    // Strobes while idle must not disturb the read data.
    hb_valid_i = 1'b1; hb_dat_i = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    hb_valid_i = 1'b0;
    n_vec++;
    if (wb_dat_o !== exp_q.pop_front()) begin
      n_bad++;
      $display("FAIL idle_valid_ignored got %h exp 22221111", wb_dat_o);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write("wr_full", 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    test_write("wr_sel4", 32'h0000_0010, 32'h1357_9BDF, 4'b0100);
    test_read("rd_reg", 32'h8000_0004, 16'h1234, 16'hABCD);
    for (int i = 0; i < 4; i++) begin
      test_write("wr_rand", {$urandom_range(0, 1) == 1, 31'($urandom)}, $urandom,
                 4'($urandom_range(0, 15)));
      test_read("rd_rand", {$urandom_range(0, 1) == 1, 31'($urandom)},
                16'($urandom), 16'($urandom));
    end
    test_timeout();
    test_handshake_wins();
    test_reset_in_wr1();
    test_cyc_drop();
    test_read("rd_after_drop", 32'h0000_0008, 16'h5555, 16'hAAAA);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
